// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial N-bit subtractor: one 1-bit full-subtractor cell is stepped
// LSB-first over N clock edges to compute a - b - borrow_in.
//
// Handshake: start is a request that is accepted only on an edge where the
// controller is IDLE. Operands are captured on that edge, busy is high for
// the N RUN cycles, and done is a single-cycle pulse during which diff,
// borrow_out and zero are valid. These result outputs keep their value until
// the next accepted operation finishes or rst is asserted.

// Combinational 1-bit full subtractor: d = x - y - bin, with a borrow out.
module fs_cell (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
endmodule

module serial_subtractor_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         borrow_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         zero,
  output logic [1:0]   state_o
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_sh_q, b_sh_q, diff_sh_q;
  logic          brw_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  diff_q;
  logic          bout_q;
  logic          zero_q;

  logic          cell_d, cell_bout;
  logic [N-1:0]  d_vec;
  logic [N-1:0]  diff_next;

  // The single shared cell always looks at the current LSBs and running borrow.
  fs_cell u_cell (
    .x_i    (a_sh_q[0]),
    .y_i    (b_sh_q[0]),
    .bin_i  (brw_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  // New difference bit enters at the MSB so that after N shifts bit 0 is LSB.
  always_comb begin
    d_vec        = '0;
    d_vec[N-1]   = cell_d;
    diff_next    = (diff_sh_q >> 1) | d_vec;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: DONE always lasts one cycle, start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, per-bit shifting and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      brw_q     <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q    <= a;
            b_sh_q    <= b;
            brw_q     <= borrow_in;
            diff_sh_q <= '0;
            cnt_q     <= '0;
          end
        end
        RUN: begin
          a_sh_q    <= a_sh_q >> 1;
          b_sh_q    <= b_sh_q >> 1;
          diff_sh_q <= diff_next;
          brw_q     <= cell_bout;
          cnt_q     <= cnt_q + CW'(1);
          // Last bit: publish the complete result, held until the next op ends.
          if (cnt_q == LAST) begin
            diff_q <= diff_next;
            bout_q <= cell_bout;
            zero_q <= (diff_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign zero       = zero_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: an N=4 instance exercised with directed
// and exhaustive vectors, plus an N=1 instance covering all 8 cases.
// Drivers push expected {zero, borrow_out, diff} into queues; monitors pop
// and compare on every done pulse.
module tb_serial_subtractor_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- N=4 DUT ----------------
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4, zero4;
  logic [3:0] diff4;
  logic [1:0] state4;

  serial_subtractor_ctrl #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bout4),
    .zero(zero4), .state_o(state4)
  );

  // ---------------- N=1 DUT ----------------
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1, zero1;
  logic [0:0] diff1;
  logic [1:0] state1;

  serial_subtractor_ctrl #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bout1),
    .zero(zero1), .state_o(state1)
  );

  // ---------------- scoreboard state ----------------
  logic [5:0] exp_q[$];   // {zero, borrow, diff[3:0]}
  logic [2:0] exp1_q[$];  // {zero, borrow, diff[0]}
  int         done_times[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  // Reference: plain integer subtraction, borrow when the result goes negative.
  function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y,
                                        input logic bi);
    int t;
    logic [3:0] d;
    t = int'(x) - int'(y) - int'(bi);
    d = 4'(t);
    return {(d == 4'd0), (t < 0), d};
  endfunction

  function automatic logic [2:0] model1(input logic x, input logic y, input logic bi);
    int t;
    logic d;
    t = int'(x) - int'(y) - int'(bi);
    d = t[0];
    return {(d == 1'b0), (t < 0), d};
  endfunction

  // ---------------- monitor, N=4 ----------------
  int   busy_cnt4 = 0;
  logic prev_done4 = 1'b0;
  always @(negedge clk) begin
    logic [5:0] e;
    cyc++;
    if (rst) begin
      busy_cnt4  = 0;
      prev_done4 = 1'b0;
    end else begin
      if (busy4) busy_cnt4++;
      if (done4) begin
        checks++;
        if (prev_done4) begin
          errors++;
          $display("FAIL done_width4: done high for two cycles at cyc %0d", cyc);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done4: got diff=%0d bout=%0b zero=%0b, none expected",
                   diff4, bout4, zero4);
        end else begin
          e = exp_q.pop_front();
          if ({zero4, bout4, diff4} !== e) begin
            errors++;
            $display("FAIL result4: got z=%0b b=%0b d=%0d, expected z=%0b b=%0b d=%0d",
                     zero4, bout4, diff4, e[5], e[4], e[3:0]);
          end
          checks++;
          if (busy_cnt4 != 4) begin
            errors++;
            $display("FAIL busy_len4: got %0d busy cycles, expected 4", busy_cnt4);
          end
        end
        busy_cnt4 = 0;
        done_times.push_back(cyc);
      end
      prev_done4 = done4;
    end
  end

  // ---------------- monitor, N=1 ----------------
  int busy_cnt1 = 0;
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst) begin
      busy_cnt1 = 0;
    end else begin
      if (busy1) busy_cnt1++;
      if (done1) begin
        checks++;
        if (exp1_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done1: got d=%0b b=%0b, none expected", diff1, bout1);
        end else begin
          e = exp1_q.pop_front();
          if ({zero1, bout1, diff1} !== e || busy_cnt1 != 1) begin
            errors++;
            $display("FAIL result1: got z=%0b b=%0b d=%0b busy=%0d, expected z=%0b b=%0b d=%0b busy=1",
                     zero1, bout1, diff1, busy_cnt1, e[2], e[1], e[0]);
          end
        end
        busy_cnt1 = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle4();
    int n = 0;
    @(negedge clk);
    while ((busy4 || done4) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL idle_timeout4: still busy after %0d cycles, expected idle", n);
    end
  endtask

  // Present operands in IDLE; accepted on the next posedge.
  task automatic launch4(input logic [3:0] x, input logic [3:0] y, input logic bi,
                         input bit expect_result, input bit hold);
    wait_idle4();
    a4 = x; b4 = y; bin4 = bi; start4 = 1'b1;
    if (expect_result) exp_q.push_back(model4(x, y, bi));
    @(posedge clk);
    #1;
    if (!hold) start4 = 1'b0;
  endtask

  task automatic drain4(output int lat);
    lat = 0;
    while (exp_q.size() != 0 && lat < 60) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout4: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run1(input logic x, input logic y, input logic bi);
    int n = 0;
    @(negedge clk);
    while ((busy1 || done1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    a1 = x; b1 = y; bin1 = bi; start1 = 1'b1;
    exp1_q.push_back(model1(x, y, bi));
    @(posedge clk);
    #1;
    start1 = 1'b0;
    n = 0;
    while (exp1_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp1_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout1: %0d results outstanding, expected 0", exp1_q.size());
      exp1_q.delete();
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct { logic [3:0] a; logic [3:0] b; logic bi; } vec_t;
  vec_t b2b_vecs[4];

  initial begin
    int lat;
    int n0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset_outputs4", int'({busy4, done4, diff4, bout4, zero4}), 0);
    check_val("reset_outputs1", int'({busy1, done1, diff1, bout1, zero1}), 0);

    // 1: 9 - 5 = 4, done appears on the 5th negedge after the launch edge.
    launch4(4'd9, 4'd5, 1'b0, 1'b1, 1'b0);
    check_val("busy_after_launch", int'(busy4), 1);
    drain4(lat);
    check_val("latency", lat, 5);

    // 2: borrow cases and zero flag.
    launch4(4'd3, 4'd5, 1'b0, 1'b1, 1'b0); drain4(lat);   // 14, borrow
    launch4(4'd0, 4'd0, 1'b1, 1'b1, 1'b0); drain4(lat);   // 15, borrow
    launch4(4'd7, 4'd7, 1'b0, 1'b1, 1'b0); drain4(lat);   // 0, zero
    @(negedge clk);
    check_val("zero_held", int'({zero4, diff4}), 16);

    // 3: start pulse mid-RUN is ignored; exactly one done.
    done_times.delete();
    launch4(4'd12, 4'd3, 1'b0, 1'b1, 1'b0);               // 9
    @(posedge clk); #1;
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1; bin4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    drain4(lat);
    repeat (10) @(negedge clk);
    check_val("single_done", done_times.size(), 1);

    // 4: reset mid-RUN clears outputs and suppresses done.
    done_times.delete();
    launch4(4'd3, 4'd5, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("abort_outputs", int'({busy4, done4, diff4, bout4, zero4}), 0);
    repeat (10) @(negedge clk);
    check_val("abort_no_done", done_times.size(), 0);
    launch4(4'd10, 4'd4, 1'b1, 1'b1, 1'b0); drain4(lat);  // 5

    // 5: start held high, operands change at each IDLE; done every 6 cycles.
    b2b_vecs[0] = '{4'd15, 4'd1, 1'b0};
    b2b_vecs[1] = '{4'd2,  4'd9, 1'b1};
    b2b_vecs[2] = '{4'd8,  4'd8, 1'b0};
    b2b_vecs[3] = '{4'd6,  4'd0, 1'b1};
    done_times.delete();
    foreach (b2b_vecs[i]) launch4(b2b_vecs[i].a, b2b_vecs[i].b, b2b_vecs[i].bi, 1'b1, 1'b1);
    start4 = 1'b0;
    drain4(lat);
    check_val("b2b_count", done_times.size(), 4);
    for (int i = 1; i < done_times.size(); i++)
      check_val("b2b_spacing", done_times[i] - done_times[i-1], 6);

    // 6: exhaustive N=4.
    n0 = checks;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int bi = 0; bi < 2; bi++) begin
          launch4(4'(x), 4'(y), 1'(bi), 1'b1, 1'b0);
          drain4(lat);
        end
    check_val("exhaustive_count", (checks - n0) / 2, 512);

    // 6: exhaustive N=1.
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int bi = 0; bi < 2; bi++)
          run1(1'(x), 1'(y), 1'(bi));

    repeat (4) @(negedge clk);
    check_val("leftover", exp_q.size() + exp1_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
